// File: rtl/muldiv_seq_if.sv
`default_nettype none
// muldiv_seq_if : EX-stage request/response bundle between the pipeline and the RV32M unit (rev 1.0)
interface muldiv_seq_if;
   logic        StartE;
   logic [2:0]  FunctE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        KillE;
   logic        multiInstrStall;
   logic        DoneE;
   logic [31:0] ResultE;

   modport master (
      output StartE, FunctE, SrcAE, SrcBE, KillE,
      input  multiInstrStall, DoneE, ResultE
   );

   modport slave (
      input  StartE, FunctE, SrcAE, SrcBE, KillE,
      output multiInstrStall, DoneE, ResultE
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// muldiv_seq : iterative RV32M multiply/divide, 32 BUSY cycles, one bit per cycle (rev 1.0)
module muldiv_seq (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_seq_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic [2:0]  funct_q;
   logic [31:0] opnd_q, hi_q, lo_q, res_q;
   logic        neg_q, neg_rem_q, done_q;

   logic        a_sgn, b_sgn, div0, ovf;
   logic [31:0] a_mag, b_mag, special_res;
   logic [32:0] mul_sum, r_sh;
   logic [31:0] sub, hi_d, lo_d, quot_s, rem_s, final_d;
   logic        ge;
   logic [63:0] prod_s;

   always_comb begin
      a_sgn = bus.SrcAE[31] & (bus.FunctE == 3'b001 || bus.FunctE == 3'b010 ||
                               bus.FunctE == 3'b100 || bus.FunctE == 3'b110);
      b_sgn = bus.SrcBE[31] & (bus.FunctE == 3'b001 || bus.FunctE == 3'b100 ||
                               bus.FunctE == 3'b110);
      a_mag = a_sgn ? -bus.SrcAE : bus.SrcAE;
      b_mag = b_sgn ? -bus.SrcBE : bus.SrcBE;
      div0  = bus.FunctE[2] && (bus.SrcBE == 32'd0);
      ovf   = (bus.FunctE == 3'b100 || bus.FunctE == 3'b110) &&
              (bus.SrcAE == 32'h8000_0000) && (bus.SrcBE == 32'hFFFF_FFFF);
      if (div0)
         special_res = bus.FunctE[1] ? bus.SrcAE : 32'hFFFF_FFFF;
      else
         special_res = bus.FunctE[1] ? 32'd0 : 32'h8000_0000;
   end

   // hi_q:lo_q is the product (mul) or remainder:quotient-shift pair (div)
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
      r_sh    = {hi_q, lo_q[31]};
      ge      = (r_sh >= {1'b0, opnd_q});
      sub     = r_sh[31:0] - opnd_q;
      if (funct_q[2]) begin
         hi_d = ge ? sub : r_sh[31:0];
         lo_d = {lo_q[30:0], ge};
      end else begin
         hi_d = mul_sum[32:1];
         lo_d = {mul_sum[0], lo_q[31:1]};
      end
      prod_s = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
      quot_s = neg_q ? -lo_d : lo_d;
      rem_s  = neg_rem_q ? -hi_d : hi_d;
      case (funct_q)
         3'b000:          final_d = prod_s[31:0];
         3'b100, 3'b101:  final_d = quot_s;
         3'b110, 3'b111:  final_d = rem_s;
         default:         final_d = prod_s[63:32];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         funct_q   <= 3'd0;
         opnd_q    <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         res_q     <= 32'd0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         res_q  <= 32'd0;
         case (state_q)
            S_IDLE: begin
               if (bus.StartE && !bus.KillE) begin
                  funct_q   <= bus.FunctE;
                  neg_q     <= a_sgn ^ b_sgn;
                  neg_rem_q <= a_sgn;
                  cnt_q     <= 6'd0;
                  hi_q      <= 32'd0;
                  opnd_q    <= bus.FunctE[2] ? b_mag : a_mag;
                  lo_q      <= bus.FunctE[2] ? a_mag : b_mag;
                  if (div0 || ovf) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     res_q   <= special_res;
                  end else begin
                     state_q <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (bus.KillE) begin
                  state_q <= S_IDLE;
               end else begin
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == 6'd31) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     res_q   <= final_d;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // A kill in the DONE cycle squashes the result the pipeline would otherwise retire
   assign bus.DoneE           = done_q & ~bus.KillE;
   assign bus.ResultE         = bus.DoneE ? res_q : 32'd0;
   assign bus.multiInstrStall = rst_n & ~bus.KillE &
                                (((state_q == S_IDLE) & bus.StartE) | (state_q == S_BUSY));
endmodule
`default_nettype wire
